apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB memory slave that supersedes the fixed-size data-memory model behind the core's `dmem_apb` port. Adds a configurable base address and depth, byte-lane writes via `pstrb`, programmable wait states, and `pslverr` on out-of-range accesses. Exposes the full array on a debug port so core benches can check stores directly. Sits on the slave side of an `apb_if` link, in benches or in an SoC memory map.

## Interface
- `DEPTH`, 64: number of `DATA_W` words; power of two, at least 2.
- `DATA_W`, 32: data width; multiple of 8. `STRB_W = DATA_W/8`.
- `ADDR_W`, 32: address width.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `DEPTH*STRB_W`.
- `WAIT_STATES`, 0: ACCESS cycles with `pready` low before completion, range 0..15.

Ports:
- `clk`, input, 1: clock; every state element updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `apb`, apb_if.slave, –: carries `paddr[ADDR_W]`, `psel`, `penable`, `pwrite`, `pwdata[DATA_W]`, `pstrb[STRB_W]` as inputs, and `prdata[DATA_W]`, `pready`, `pslverr` as outputs.
- `mem_o`, output, `DEPTH` x `DATA_W`: debug view of the array; purely a copy, with no side effects.

## Operation
- Reset values: every memory word is 0; `prdata`, `pready` and `pslverr` are 0; FSM is in IDLE; wait counter is 0.
- FSM states:
  - IDLE → SETUP when `psel & ~penable`.
  - SETUP → ACCESS on the next edge.
  - ACCESS → IDLE on the edge where `pready` is 1.
  - ACCESS → IDLE if `psel` or `penable` drops before completion. This is a protocol abort: no write occurs, and no response is given.
  - `psel & penable` seen while in IDLE is ignored.
- Decode: `idx = (paddr - BASE_ADDR) >> log2(STRB_W)`. `paddr[log2(STRB_W)-1:0]` is ignored.
  - `oob` is set when `paddr < BASE_ADDR` or `idx >= DEPTH`.
  - The decode is computed and latched at the end of SETUP.
- Writes commit on the completing ACCESS edge, only when `~oob`. For each lane `b` with `pstrb[b]=1`, byte `b` of `mem[idx]` takes `pwdata` byte `b`. `pstrb = 0` completes normally and changes nothing.
- Reads load `prdata <= mem[idx]` at the end of SETUP. `prdata` holds its value through ACCESS and afterwards, until the next read's SETUP. An `oob` read loads 0.
- `pslverr` equals the latched `oob`, qualified by `pready`; it is 0 whenever `pready` is 0.
- Back-to-back write then read to the same address returns the new data, because the write commits before the read's SETUP edge.

## Timing
- The wait counter is loaded with the wait count at the end of SETUP and decrements each ACCESS cycle while nonzero.
- `pready` is registered. It is 1 only in the ACCESS cycle where the counter is 0.
- Transfer length is SETUP plus `WAIT_STATES+1` ACCESS cycles. With `WAIT_STATES=0` that is 2 cycles.
- `pready` is 0 in IDLE and in SETUP.
- Asserting `rst` mid-transfer immediately drops `pready` and `pslverr` and zeroes the array. A pending write is lost.

## Configuration
- `APB_MEM_RAND_WAIT_EN` defined:
  - A 16-bit maximal-length LFSR with nonzero seed `16'hACE1` advances once per completed transfer.
  - Its two LSBs are added to `WAIT_STATES` at the SETUP load, giving 0..3 extra cycles.
  - Reset reloads the seed.
  - Purpose: stressing core stall paths.
- Undefined: the wait count is exactly `WAIT_STATES` and no LFSR logic exists.

## Structure
- `apb_pkg` holds:
  - `apb_mem_state_e` (IDLE, SETUP, ACCESS);
  - `APB_LFSR_SEED`;
  - a `clog2`-based index width helper shared with other APB slaves.
- One sub-module, `apb_wait_lfsr`, instantiated only under `APB_MEM_RAND_WAIT_EN`.
- The array is a plain register array; no RAM macro.

## Test plan
- Reset, then `mem_o`: every word is 0, and `pready` and `pslverr` are 0 throughout reset.
- Write byte lanes: `WAIT_STATES=0`, write `32'hAAAAAAAA` with `pstrb=4'hF` to `0x18`, then `32'h00000368` with `pstrb=4'h3` to `0x18`.
  - Required: `mem_o[6] = 32'hAAAA0368`.
  - Required: each transfer completes 2 cycles after SETUP.
- Wait states: `WAIT_STATES=3`, read `0x18`.
  - Required: `pready` is low for exactly 3 ACCESS cycles, then high for 1 cycle with `prdata = 32'hAAAA0368`.
- Out of range: `BASE_ADDR=0x1000`.
  - Write to `0x0FFC`: `pslverr=1` with `pready`, array unchanged.
  - Read `0x1100`: `pslverr=1`, `prdata=0`.
- Back-to-back: write 66408 to `0x0`, followed immediately by a read of `0x0`.
  - Required: the read returns 66408.
- Abort and reset: drop `penable` in the 2nd ACCESS cycle of a write, and separately assert `rst` mid-ACCESS.
  - Required: neither case writes memory.
  - Required: after `rst`, the FSM is IDLE and the outputs are 0.
  - With `APB_MEM_RAND_WAIT_EN`: 100 reads all complete in 1..4 ACCESS cycles with correct data.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: memory-slave FSM states, wait LFSR seed and
// the index-width helper used by word-addressed APB slaves.
package apb_pkg;

    // Memory-slave transfer phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mem_state_e;

    // Nonzero seed for the random wait-state LFSR.
    localparam logic [15:0] APB_LFSR_SEED = 16'hACE1;

    // Width of a word index into an array of 'depth' entries (at least 1 bit).
    function automatic int unsigned apb_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB link between one master and one slave.
interface apb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that supplies
// 0..3 extra wait states; steps once per completed transfer.
module apb_wait_lfsr
    import apb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    output logic [1:0] extra_o
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: shift right, feedback into the MSB.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= APB_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign extra_o = lfsr_q[1:0];
endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with byte-lane writes, programmable wait
// states, pslverr on out-of-range accesses and a debug copy of the array.
// Optional feature: define APB_MEM_RAND_WAIT_EN to add 0..3 LFSR-driven
// extra wait states per transfer.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned        DEPTH       = 64,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    apb_if.slave              apb,
    output logic [DATA_W-1:0] mem_o [DEPTH]
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = apb_idx_w(DEPTH);
    localparam int unsigned CNT_W  = 5;

    apb_mem_state_e    state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              oob_q, oob_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [ADDR_W:0]   diff_c;
    logic [ADDR_W-1:0] word_c;
    logic [IDX_W-1:0]  idx_c;
    logic              oob_c;
    logic [CNT_W-1:0]  wait_ld_c;

    // Address decode; the borrow bit of the subtraction flags paddr < BASE_ADDR.
    assign diff_c = {1'b0, apb.paddr} - {1'b0, BASE_ADDR};
    assign word_c = diff_c[ADDR_W-1:0] >> OFS_W;
    assign idx_c  = word_c[IDX_W-1:0];
    assign oob_c  = diff_c[ADDR_W] | (word_c >= ADDR_W'(DEPTH));

`ifdef APB_MEM_RAND_WAIT_EN
    logic [1:0] lfsr_extra;
    logic       done_c;

    assign done_c = (state_q == ACCESS) && pready_q;

    apb_wait_lfsr u_wait_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (done_c),
        .extra_o (lfsr_extra)
    );

    // Wait count: fixed base plus 0..3 pseudo-random extra cycles.
    assign wait_ld_c = CNT_W'(WAIT_STATES) + CNT_W'(lfsr_extra);
`else
    assign wait_ld_c = CNT_W'(WAIT_STATES);
`endif

    // Transfer FSM, wait counter, read data capture and byte-lane write commit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        oob_d     = oob_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        mem_d     = mem_q;

        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                idx_d     = idx_c;
                oob_d     = oob_c;
                cnt_d     = wait_ld_c;
                pready_d  = (wait_ld_c == '0);
                pslverr_d = (wait_ld_c == '0) && oob_c;
                if (!apb.pwrite) begin
                    prdata_d = oob_c ? '0 : mem_q[idx_c];
                end
            end
            ACCESS: begin
                if (pready_q) begin
                    state_d = IDLE;
                    if (apb.pwrite && !oob_q) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (apb.pstrb[b]) begin
                                mem_d[idx_q][8*b +: 8] = apb.pwdata[8*b +: 8];
                            end
                        end
                    end
                end else if (!(apb.psel && apb.penable)) begin
                    // Master abandoned the transfer: no write, no response.
                    state_d = IDLE;
                end else begin
                    cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
                    pready_d  = (cnt_q <= CNT_W'(1));
                    pslverr_d = (cnt_q <= CNT_W'(1)) && oob_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the whole array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            oob_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            oob_q     <= oob_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            mem_q     <= mem_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign mem_o       = mem_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three slave configurations driven by a transfer-level
// master, checked every cycle against a per-instance memory/response model.
module tb_apb_mem_slave;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-instance master drive.
    logic        m_psel [NI];
    logic        m_pen  [NI];
    logic        m_pwr  [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_wd   [NI];
    logic [3:0]  m_strb [NI];

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.psel = m_psel[0]; assign bus0.penable = m_pen[0]; assign bus0.pwrite = m_pwr[0];
    assign bus0.paddr = m_addr[0]; assign bus0.pwdata = m_wd[0]; assign bus0.pstrb = m_strb[0];
    assign bus1.psel = m_psel[1]; assign bus1.penable = m_pen[1]; assign bus1.pwrite = m_pwr[1];
    assign bus1.paddr = m_addr[1]; assign bus1.pwdata = m_wd[1]; assign bus1.pstrb = m_strb[1];
    assign bus2.psel = m_psel[2]; assign bus2.penable = m_pen[2]; assign bus2.pwrite = m_pwr[2];
    assign bus2.paddr = m_addr[2]; assign bus2.pwdata = m_wd[2]; assign bus2.pstrb = m_strb[2];

    logic [31:0] memo0 [64];
    logic [31:0] memo1 [64];
    logic [31:0] memo2 [16];

    apb_mem_slave #(.DEPTH(64), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .WAIT_STATES(0))
        dut0 (.clk(clk), .rst(rst), .apb(bus0), .mem_o(memo0));
    apb_mem_slave #(.DEPTH(64), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .WAIT_STATES(3))
        dut1 (.clk(clk), .rst(rst), .apb(bus1), .mem_o(memo1));
    apb_mem_slave #(.DEPTH(16), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h1000), .WAIT_STATES(1))
        dut2 (.clk(clk), .rst(rst), .apb(bus2), .mem_o(memo2));

    function automatic int dep_of(input int k);
        return (k == 2) ? 16 : 64;
    endfunction
    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 1);
    endfunction
    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h1000 : 32'h0;
    endfunction

    function automatic logic dut_pready(input int k);
        return (k == 0) ? bus0.pready : ((k == 1) ? bus1.pready : bus2.pready);
    endfunction
    function automatic logic dut_pslverr(input int k);
        return (k == 0) ? bus0.pslverr : ((k == 1) ? bus1.pslverr : bus2.pslverr);
    endfunction
    function automatic logic [31:0] dut_prdata(input int k);
        return (k == 0) ? bus0.prdata : ((k == 1) ? bus1.prdata : bus2.prdata);
    endfunction
    function automatic logic [31:0] dut_mem(input int k, input int i);
        if (k == 0) return memo0[i];
        if (k == 1) return memo1[i];
        return memo2[i % 16];
    endfunction

    // Reference model: memory contents and the expected bus outputs this cycle.
    logic [31:0] mm [NI][64];
    logic        exp_pready  [NI];
    logic        exp_pslverr [NI];
    logic [31:0] exp_prdata  [NI];
`ifdef APB_MEM_RAND_WAIT_EN
    bit hs_chk = 1'b0;
`else
    bit hs_chk = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 64; i++) mm[k][i] = '0;
            exp_pready[k]  = 1'b0;
            exp_pslverr[k] = 1'b0;
            exp_prdata[k]  = '0;
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int bad;
            if (hs_chk) begin
                chk($sformatf("pready[%0d]", k), {31'd0, dut_pready(k)}, {31'd0, exp_pready[k]});
                chk($sformatf("pslverr[%0d]", k), {31'd0, dut_pslverr(k)}, {31'd0, exp_pslverr[k]});
            end
            chk($sformatf("prdata[%0d]", k), dut_prdata(k), exp_prdata[k]);
            bad = -1;
            for (int i = 0; i < dep_of(k); i++) begin
                if (bad < 0 && dut_mem(k, i) !== mm[k][i]) bad = i;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL mem[%0d][%0d]: got %h want %h", k, bad, dut_mem(k, bad), mm[k][bad]);
            end
        end
    end

    // One APB transfer on instance k, entered and left at posedge+1.
    // kill: 0 = normal, 1 = master drops psel/penable, 2 = reset; at ACCESS cycle kill_at.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input int kill, input int kill_at,
                        output logic [31:0] rd, output logic err, output int nacc);
        logic [31:0] rel;
        bit          oob;
        int          idx;
        bit          done;
        rel  = addr - base_of(k);
        oob  = (addr < base_of(k)) || ((rel >> 2) >= 32'(dep_of(k)));
        idx  = oob ? 0 : int'(rel >> 2);
        rd   = '0;
        err  = 1'b0;
        nacc = 0;
        done = 1'b0;
        // Bus setup cycle.
        m_psel[k] = 1'b1; m_pen[k] = 1'b0; m_pwr[k] = wr;
        m_addr[k] = addr; m_wd[k] = wd;   m_strb[k] = strb;
        exp_pready[k] = 1'b0; exp_pslverr[k] = 1'b0;
        @(posedge clk); #1;
        m_pen[k] = 1'b1;
        @(posedge clk); #1;
        if (!wr) exp_prdata[k] = oob ? 32'h0 : mm[k][idx];
        while (!done) begin
            nacc++;
`ifdef APB_MEM_RAND_WAIT_EN
            done = dut_pready(k);
            if (!done && nacc > ws_of(k) + 4) begin
                chk("wait_bound", 32'(nacc), 32'(ws_of(k) + 4));
                done = 1'b1;
            end
`else
            done = (nacc == ws_of(k) + 1);
            exp_pready[k]  = done;
            exp_pslverr[k] = done && oob;
`endif
            if (kill != 0 && nacc - 1 == kill_at && !done) begin
                m_psel[k] = 1'b0; m_pen[k] = 1'b0;
                if (kill == 2) begin
                    rst = 1'b1;
                    clear_model();
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                end else begin
                    @(posedge clk); #1;
                    exp_pready[k] = 1'b0; exp_pslverr[k] = 1'b0;
                end
                return;
            end
            if (done) begin
                rd  = dut_prdata(k);
                err = dut_pslverr(k);
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        if (wr && !oob) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mm[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        m_psel[k] = 1'b0; m_pen[k] = 1'b0;
        exp_pready[k] = 1'b0; exp_pslverr[k] = 1'b0;
`ifdef APB_MEM_RAND_WAIT_EN
        chk("rand_lat_ok", 32'((nacc >= ws_of(k) + 1) && (nacc <= ws_of(k) + 4)), 32'd1);
        chk("rand_err", {31'd0, err}, {31'd0, oob});
`endif
    endtask

    logic [31:0] rd;
    logic        err;
    int          nacc;
    logic [31:0] ra;
    bit          rw;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_model();
        for (int k = 0; k < NI; k++) begin
            m_psel[k] = 1'b0; m_pen[k] = 1'b0; m_pwr[k] = 1'b0;
            m_addr[k] = '0;   m_wd[k] = '0;    m_strb[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_mem0_6", memo0[6], 32'h0);
        chk("reset_pready0", {31'd0, bus0.pready}, 32'd0);

        // Byte-lane writes on the zero-wait and three-wait instances.
        for (int k = 0; k < 2; k++) begin
            xfer(k, 1'b1, 32'h18, 32'hAAAAAAAA, 4'hF, 0, 0, rd, err, nacc);
`ifndef APB_MEM_RAND_WAIT_EN
            if (k == 0) chk("wr_full_len", 32'(nacc + 1), 32'd2);
`endif
            xfer(k, 1'b1, 32'h18, 32'h00000368, 4'h3, 0, 0, rd, err, nacc);
`ifndef APB_MEM_RAND_WAIT_EN
            if (k == 0) chk("wr_lane_len", 32'(nacc + 1), 32'd2);
`endif
        end
        chk("lanes_model", mm[0][6], 32'hAAAA0368);
        chk("lanes_dut0", memo0[6], 32'hAAAA0368);

        // Wait-state read.
        xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, 0, 0, rd, err, nacc);
`ifndef APB_MEM_RAND_WAIT_EN
        chk("ws3_access_cycles", 32'(nacc), 32'd4);
`endif
        chk("ws3_rdata", rd, 32'hAAAA0368);

        // Out-of-range on BASE_ADDR=0x1000, DEPTH=16.
        xfer(2, 1'b1, 32'h1004, 32'h12345678, 4'hF, 0, 0, rd, err, nacc);
        xfer(2, 1'b0, 32'h1004, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("inrange_rd", rd, 32'h12345678);
        xfer(2, 1'b1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 0, 0, rd, err, nacc);
        chk("oob_low_err", {31'd0, err}, 32'd1);
        chk("oob_low_nochg", memo2[15], 32'h0);
        xfer(2, 1'b0, 32'h1100, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("oob_high_err", {31'd0, err}, 32'd1);
        chk("oob_high_rd", rd, 32'h0);
        xfer(2, 1'b0, 32'h1040, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("oob_edge_err", {31'd0, err}, 32'd1);
        xfer(2, 1'b0, 32'h103C, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("last_word_err", {31'd0, err}, 32'd0);

        // Back-to-back write then read.
        xfer(0, 1'b1, 32'h0, 32'd66408, 4'hF, 0, 0, rd, err, nacc);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("b2b_rd", rd, 32'd66408);

        // Abort in the second ACCESS cycle of a write.
        xfer(1, 1'b1, 32'h0, 32'h11223344, 4'hF, 0, 0, rd, err, nacc);
        xfer(1, 1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 1, 1, rd, err, nacc);
        chk("abort_nowrite", memo1[0], 32'h11223344);
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("abort_recover_rd", rd, 32'h11223344);

        // Reset mid-ACCESS of a write.
        xfer(1, 1'b1, 32'h18, 32'h55555555, 4'hF, 2, 2, rd, err, nacc);
        chk("rst_mem1_6", memo1[6], 32'h0);
        chk("rst_mem0_0", memo0[0], 32'h0);
        chk("rst_pready1", {31'd0, bus1.pready}, 32'd0);
        chk("rst_prdata1", bus1.prdata, 32'h0);
        xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        chk("rst_lost_write", rd, 32'h0);
`ifndef APB_MEM_RAND_WAIT_EN
        chk("rst_idle_len", 32'(nacc), 32'd4);
`endif

        // Randomized traffic, including addresses just outside each window.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 60; n++) begin
                ra = base_of(k) - 32'd16 + 32'($urandom_range(0, dep_of(k) * 4 + 31));
                rw = 1'($urandom_range(0, 1));
                xfer(k, rw, ra, $urandom, 4'($urandom), 0, 0, rd, err, nacc);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end

`ifdef APB_MEM_RAND_WAIT_EN
        // Randomized wait states: every read completes within 1..4 ACCESS cycles.
        for (int n = 0; n < 100; n++) begin
            ra = 32'($urandom_range(0, 63)) << 2;
            xfer(0, 1'b0, ra, 32'h0, 4'h0, 0, 0, rd, err, nacc);
        end
`endif

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
